// File: rtl/valu_pkg.sv
// Shared widths, occupancy-width helper and the writeback beat type for the vALU writeback path.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package valu_pkg;

  localparam int VALU_ADDR_W = 32;
  localparam int VALU_DATA_W = 64;

  // Occupancy counters need one extra bit so that "full" (== DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [VALU_ADDR_W-1:0] addr;
    logic [VALU_DATA_W-1:0] data;
  } wb_beat_t;

endpackage

// File: rtl/valu_wb_fifo_mem.sv
// Storage array for the writeback FIFO: synchronous write, asynchronous read.
// Latency: written entry is readable the cycle after the write edge; read is combinational.
// Backpressure: none; the owner decides when to write.
module valu_wb_fifo_mem #(
  parameter int W     = 96,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Entries are not reset: the owner never presents an entry it has not written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/valu_wb_buffer.sv
// Writeback buffer between fixed-latency vALU pipelines and the vector register-file write port.
// Latency: 1 cycle from in_valid on an empty buffer to wb_valid (0 cycles with VALU_WB_BYPASS_EN).
// Backpressure: wb_ready stalls the drain; input cannot be stalled, issue_stall warns PIPE_LAT beats early.
// Optional feature macro: VALU_WB_BYPASS_EN (same-cycle input-to-writeback path when empty).
module valu_wb_buffer
  import valu_pkg::*;
#(
  parameter int REQ_ADDR_WIDTH  = VALU_ADDR_W,
  parameter int RESP_DATA_WIDTH = VALU_DATA_W,
  parameter int DEPTH           = 8,  // power of two, >= PIPE_LAT+2
  parameter int PIPE_LAT        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_ADDR_WIDTH-1:0]   in_addr,
  input  logic [RESP_DATA_WIDTH-1:0]  in_vec,
  input  logic                        in_valid,
  output logic [REQ_ADDR_WIDTH-1:0]   wb_addr,
  output logic [RESP_DATA_WIDTH-1:0]  wb_data,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic                        issue_stall,
  output logic [cnt_w(DEPTH)-1:0]     count,
  output logic                        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int BW = REQ_ADDR_WIDTH + RESP_DATA_WIDTH;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - PIPE_LAT);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [BW-1:0] head;
  logic [BW-1:0] out_beat;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic          bypass;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  valu_wb_fifo_mem #(
    .W     (BW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata ({in_addr, in_vec}),
    .raddr (rd_ptr),
    .rdata (head)
  );

`ifdef VALU_WB_BYPASS_EN
  // An empty buffer with a ready register file hands the beat straight through without storing it.
  assign bypass   = empty & in_valid & wb_ready;
  assign wb_valid = ~empty | in_valid;
  assign out_beat = empty ? {in_addr, in_vec} : head;
`else
  assign bypass   = 1'b0;
  assign wb_valid = ~empty;
  assign out_beat = head;
`endif

  // Only stored entries are popped; a bypassed beat never touched the array.
  assign do_pop  = wb_valid & wb_ready & ~empty;
  // A full buffer still accepts a beat when the head leaves in the same cycle.
  assign do_push = in_valid & ~bypass & (~full | do_pop);
  assign drop    = in_valid & full & ~do_pop;

  assign wb_addr     = wb_valid ? out_beat[BW-1:RESP_DATA_WIDTH]  : '0;
  assign wb_data     = wb_valid ? out_beat[RESP_DATA_WIDTH-1:0]   : '0;
  assign issue_stall = (count >= STALL_CNT);

  // Pointer, occupancy and sticky overflow update; reset drops any beat arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_valu_wb_buffer.sv
// Directed self-checking bench for valu_wb_buffer (default DEPTH=8, PIPE_LAT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Bypass-dependent expectations follow VALU_WB_BYPASS_EN.
module tb_valu_wb_buffer;
  import valu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] in_addr;
  logic [63:0] in_vec;
  logic        in_valid;
  logic [31:0] wb_addr;
  logic [63:0] wb_data;
  logic        wb_valid;
  logic        wb_ready;
  logic        issue_stall;
  logic [3:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  wb_beat_t exp_q[$];

  valu_wb_buffer #(
    .REQ_ADDR_WIDTH  (32),
    .RESP_DATA_WIDTH (64),
    .DEPTH           (8),
    .PIPE_LAT        (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_addr     (in_addr),
    .in_vec      (in_vec),
    .in_valid    (in_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .issue_stall (issue_stall),
    .count       (count),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0; in_addr = '0; in_vec = '0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if ({wb_valid, wb_addr, wb_data, issue_stall, count, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b addr=%h data=%h stall=%0b count=%0d ovf=%0b, expected all zero",
               wb_valid, wb_addr, wb_data, issue_stall, count, overflow);
    end
    tick;
  endtask

  task automatic test_single;
    in_addr = 32'h10; in_vec = 64'hA5A5; in_valid = 1'b1; wb_ready = 1'b1;
    #1;
`ifdef VALU_WB_BYPASS_EN
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 64'hA5A5) begin
      errors++;
      $display("FAIL single_bypass: valid=%0b data=%h, expected 1 / a5a5", wb_valid, wb_data);
    end
    tick;
    in_valid = 1'b0;
    #1;
`else
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_same_cycle: wb_valid=%0b, expected 0", wb_valid);
    end
    tick;
    in_valid = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_addr !== 32'h10 || wb_data !== 64'hA5A5) begin
      errors++;
      $display("FAIL single_out: valid=%0b addr=%h data=%h, expected 1 / 10 / a5a5", wb_valid, wb_addr, wb_data);
    end
    tick;
`endif
    checks++;
    if (count !== 4'd0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drained: count=%0d valid=%0b, expected 0 / 0", count, wb_valid);
    end
  endtask

  task automatic test_fill;
    wb_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_addr = 32'h100 + i; in_vec = 64'h1000 + i;
      tick;
      checks++;
      if (count !== 4'(i + 1) || issue_stall !== (i + 1 >= 4)) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d stall=%0b, expected %0d / %0b", i, count, issue_stall, i + 1, (i + 1 >= 4));
      end
    end
    in_addr = 32'h1FF; in_vec = 64'h1FFF;
    tick;
    in_valid = 1'b0;
    #1;
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8 || wb_addr !== 32'h100 || wb_data !== 64'h1000) begin
      errors++;
      $display("FAIL fill_overflow: ovf=%0b count=%0d addr=%h data=%h, expected 1 / 8 / 100 / 1000",
               overflow, count, wb_addr, wb_data);
    end
  endtask

  task automatic test_reset_mid;
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_addr !== 32'h100 + i || wb_data !== 64'h1000 + i) begin
        errors++;
        $display("FAIL midreset_pop_%0d: valid=%0b addr=%h data=%h, expected 1 / %h / %h",
                 i, wb_valid, wb_addr, wb_data, 32'h100 + i, 64'h1000 + i);
      end
      tick;
    end
    wb_ready = 1'b0;
    #1;
    checks++;
    if (count !== 4'd5 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: count=%0d ovf=%0b, expected 5 / 1", count, overflow);
    end
    rst = 1'b1; in_valid = 1'b1; in_addr = 32'h55; in_vec = 64'h55;
    tick;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || wb_valid !== 1'b0 || wb_data !== 64'h0 || overflow !== 1'b0 || issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL midreset_post: count=%0d valid=%0b data=%h ovf=%0b stall=%0b, expected all zero",
               count, wb_valid, wb_data, overflow, issue_stall);
    end
  endtask

  task automatic test_full_push_pop;
    wb_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_addr = 32'h200 + i; in_vec = 64'h2000 + i;
      tick;
    end
    in_addr = 32'h208; in_vec = 64'h2008; wb_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: count=%0d ovf=%0b, expected 8 / 0", count, overflow);
    end
    for (int j = 0; j < 8; j++) begin
      #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_addr !== 32'h201 + j || wb_data !== 64'h2001 + j) begin
        errors++;
        $display("FAIL full_drain_%0d: valid=%0b addr=%h data=%h, expected 1 / %h / %h",
                 j, wb_valid, wb_addr, wb_data, 32'h201 + j, 64'h2001 + j);
      end
      tick;
    end
    checks++;
    if (count !== 4'd0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: count=%0d valid=%0b, expected 0 / 0", count, wb_valid);
    end
  endtask

  task automatic test_wrap;
    int sent;
    int got;
    wb_beat_t exp;
    sent = 0;
    got  = 0;
    exp_q.delete();
    for (int c = 0; c < 140; c++) begin
      if (c >= 40 && exp_q.size() == 0) break;
      in_valid = (c % 2 == 0) && (sent < 20);
      wb_ready = (c >= 40) || ((c / 3) % 2 == 0);
      in_addr  = 32'h300 + sent;
      in_vec   = 64'hBEEF_0000 + 64'(sent * 7);
      if (in_valid) begin
        exp.addr = in_addr;
        exp.data = in_vec;
        exp_q.push_back(exp);
        sent++;
      end
      #1;
      if (wb_valid && wb_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wrap_spurious: addr=%h data=%h with nothing outstanding", wb_addr, wb_data);
        end else begin
          exp = exp_q.pop_front();
          got++;
          if (wb_addr !== exp.addr || wb_data !== exp.data) begin
            errors++;
            $display("FAIL wrap_order: addr=%h data=%h, expected %h / %h", wb_addr, wb_data, exp.addr, exp.data);
          end
        end
      end
      tick;
      checks++;
      if (count !== 4'(exp_q.size())) begin
        errors++;
        $display("FAIL wrap_count: count=%0d, expected %0d", count, exp_q.size());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 20 || overflow !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_total: got=%0d ovf=%0b count=%0d, expected 20 / 0 / 0", got, overflow, count);
    end
  endtask

  task automatic test_bypass;
    in_valid = 1'b1; wb_ready = 1'b1; in_addr = 32'h7; in_vec = 64'h77;
    #1;
`ifdef VALU_WB_BYPASS_EN
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 64'h77 || wb_addr !== 32'h7) begin
      errors++;
      $display("FAIL bypass_same_cycle: valid=%0b addr=%h data=%h, expected 1 / 7 / 77", wb_valid, wb_addr, wb_data);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL bypass_count: count=%0d, expected 0", count);
    end
`else
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== 64'h0) begin
      errors++;
      $display("FAIL nobypass_same_cycle: valid=%0b data=%h, expected 0 / 0", wb_valid, wb_data);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd1 || wb_valid !== 1'b1 || wb_data !== 64'h77) begin
      errors++;
      $display("FAIL nobypass_next: count=%0d valid=%0b data=%h, expected 1 / 1 / 77", count, wb_valid, wb_data);
    end
    tick;
`endif
    // Bypass requested while the register file is busy: the beat must be stored and held stable.
    in_valid = 1'b1; wb_ready = 1'b0; in_addr = 32'h8; in_vec = 64'h88;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (count !== 4'd1 || wb_valid !== 1'b1 || wb_addr !== 32'h8 || wb_data !== 64'h88) begin
      errors++;
      $display("FAIL held_beat: count=%0d valid=%0b addr=%h data=%h, expected 1 / 1 / 8 / 88",
               count, wb_valid, wb_addr, wb_data);
    end
    wb_ready = 1'b1;
    tick;
    checks++;
    if (count !== 4'd0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_drain: count=%0d valid=%0b, expected 0 / 0", count, wb_valid);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_reset_mid;
    test_full_push_pop;
    test_wrap;
    test_bypass;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
